// File: rtl/pdp8_pkg.sv
// Shared PDP-8 definitions: CPU major states, device-00 IOT function codes
// and the interrupt-enable state encoding.
package pdp8_pkg;

    typedef enum logic [3:0] {
        ST_F0 = 4'd0,
        ST_F1 = 4'd1,
        ST_F2 = 4'd2,
        ST_F3 = 4'd3
    } cpu_state_t;

    typedef enum logic [2:0] {
        FN_SKON = 3'd0,
        FN_ION  = 3'd1,
        FN_IOF  = 3'd2,
        FN_SRQ  = 3'd3,
        FN_SINH = 3'd4,
        FN_CAF  = 3'd7
    } iot_fn_t;

    typedef enum logic [1:0] {
        IEN_OFF,
        IEN_ARM,
        IEN_DELAY,
        IEN_ON
    } ien_state_t;

endpackage

// File: rtl/pdp8_intr_en.sv
// Delayed-ION interrupt-enable FSM plus the optional CIF inhibit flop
// (present only when PDP8_INTR_INHIBIT_EN is defined).
module pdp8_intr_en
    import pdp8_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic ion_cmd,
    input  logic iof_cmd,
    input  logic skon_cmd,
    input  logic caf_cmd,
    input  logic instr_done,
    input  logic int_ack,
    input  logic cif_exec,
    input  logic jmp_jms_done,
    output logic ion,
    output logic inhibit
);

    ien_state_t ien_state;
    ien_state_t ien_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ien_state <= IEN_OFF;
        end else begin
            ien_state <= ien_next;
        end
    end

    // ARM survives the ION instruction's own instr_done only as far as DELAY,
    // so interrupts open after the instruction that follows ION.
    always_comb begin
        ien_next = ien_state;
        if (int_ack) begin
            ien_next = IEN_OFF;
        end else if (skon_cmd || iof_cmd || caf_cmd) begin
            ien_next = IEN_OFF;
        end else if (ion_cmd) begin
            if (ien_state != IEN_ON) begin
                ien_next = IEN_ARM;
            end
        end else if (instr_done) begin
            case (ien_state)
                IEN_ARM:   ien_next = IEN_DELAY;
                IEN_DELAY: ien_next = IEN_ON;
                default:   ien_next = ien_state;
            endcase
        end
    end

    assign ion = (ien_state == IEN_ON);

`ifdef PDP8_INTR_INHIBIT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inhibit <= 1'b0;
        end else if (jmp_jms_done) begin
            inhibit <= 1'b0;
        end else if (cif_exec) begin
            inhibit <= 1'b1;
        end
    end
`else
    logic unused_inhibit_ctl;
    assign unused_inhibit_ctl = cif_exec | jmp_jms_done;
    assign inhibit = 1'b0;
`endif

endmodule

// File: rtl/pdp8_intr.sv
// Device-00 interrupt/IOT-response controller: merges peripheral responses and
// raises int_req. Optional CIF inhibit via macro PDP8_INTR_INHIBIT_EN.
module pdp8_intr
    import pdp8_pkg::*;
#(
    parameter int          NDEV     = 8,
    parameter logic [5:0]  DEV_CODE = 6'o00
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            iot,
    input  logic [3:0]      state,
    input  logic [11:0]     mb,
    input  logic [5:0]      io_select,
    input  logic [NDEV-1:0] dev_selected,
    input  logic [NDEV-1:0] dev_skip,
    input  logic [NDEV-1:0] dev_interrupt,
    input  logic            instr_done,
    input  logic            int_ack,
    input  logic            cif_exec,
    input  logic            jmp_jms_done,
    output logic            io_selected,
    output logic            io_skip,
    output logic            int_req,
    output logic            ion,
    output logic            io_clear_all
);

    logic       own_sel;
    logic       own_skip;
    logic       any_int;
    logic       inhibit;
    logic [2:0] fn;
    logic       ion_cmd;
    logic       iof_cmd;
    logic       skon_cmd;
    logic       caf_cmd;
    logic       unused_mb;

    assign fn        = mb[2:0];
    assign unused_mb = ^mb[11:3];
    assign any_int   = |dev_interrupt;
    assign own_sel   = (state == ST_F1) && iot && (io_select == DEV_CODE);

    assign skon_cmd = own_sel && (fn == FN_SKON);
    assign ion_cmd  = own_sel && (fn == FN_ION);
    assign iof_cmd  = own_sel && (fn == FN_IOF);
    assign caf_cmd  = own_sel && (fn == FN_CAF);

    // SKON tests the enable state before this edge's SKON turns it off.
    always_comb begin
        own_skip = 1'b0;
        if (own_sel) begin
            case (fn)
                FN_SKON: own_skip = ion;
                FN_SRQ:  own_skip = any_int;
`ifdef PDP8_INTR_INHIBIT_EN
                FN_SINH: own_skip = inhibit;
`endif
                default: own_skip = 1'b0;
            endcase
        end
    end

    assign io_selected = (|dev_selected) | own_sel;
    assign io_skip     = (|dev_skip) | own_skip;

    pdp8_intr_en u_en (
        .clk          (clk),
        .reset_n      (reset_n),
        .ion_cmd      (ion_cmd),
        .iof_cmd      (iof_cmd),
        .skon_cmd     (skon_cmd),
        .caf_cmd      (caf_cmd),
        .instr_done   (instr_done),
        .int_ack      (int_ack),
        .cif_exec     (cif_exec),
        .jmp_jms_done (jmp_jms_done),
        .ion          (ion),
        .inhibit      (inhibit)
    );

    // dev_interrupt is sampled, not latched: a request dropped early is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            int_req      <= 1'b0;
            io_clear_all <= 1'b0;
        end else begin
            int_req      <= ion && any_int && !inhibit && !int_ack;
            io_clear_all <= caf_cmd;
        end
    end

endmodule

// File: tb/tb_pdp8_intr.sv
// Self-checking bench for pdp8_intr: directed scenarios plus randomized traffic
// against a pending-instruction-count reference model.
module tb_pdp8_intr;

    localparam int NDEV = 8;
`ifdef PDP8_INTR_INHIBIT_EN
    localparam bit INH_EN = 1'b1;
`else
    localparam bit INH_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic            iot;
    logic [3:0]      state;
    logic [11:0]     mb;
    logic [5:0]      io_select;
    logic [NDEV-1:0] dev_selected;
    logic [NDEV-1:0] dev_skip;
    logic [NDEV-1:0] dev_interrupt;
    logic            instr_done;
    logic            int_ack;
    logic            cif_exec;
    logic            jmp_jms_done;
    logic            io_selected;
    logic            io_skip;
    logic            int_req;
    logic            ion;
    logic            io_clear_all;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: enabled flag plus number of instr_done still owed
    bit m_on;
    int m_pend;
    bit m_req;
    bit m_clr;
    bit m_inh;

    always #5 clk = ~clk;

    pdp8_intr #(.NDEV(NDEV), .DEV_CODE(6'o00)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .iot           (iot),
        .state         (state),
        .mb            (mb),
        .io_select     (io_select),
        .dev_selected  (dev_selected),
        .dev_skip      (dev_skip),
        .dev_interrupt (dev_interrupt),
        .instr_done    (instr_done),
        .int_ack       (int_ack),
        .cif_exec      (cif_exec),
        .jmp_jms_done  (jmp_jms_done),
        .io_selected   (io_selected),
        .io_skip       (io_skip),
        .int_req       (int_req),
        .ion           (ion),
        .io_clear_all  (io_clear_all)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit own_now();
        return (state == 4'd1) && iot && (io_select == 6'o00);
    endfunction

    function automatic bit skip_now();
        bit o;
        o = own_now();
        return (dev_skip != 0) ||
               (o && mb[2:0] == 3'd0 && m_on) ||
               (o && mb[2:0] == 3'd3 && dev_interrupt != 0) ||
               (o && mb[2:0] == 3'd4 && INH_EN && m_inh);
    endfunction

    task automatic model_reset();
        m_on = 0; m_pend = 0; m_req = 0; m_clr = 0; m_inh = 0;
    endtask

    task automatic model_step();
        bit o;
        bit n_req;
        bit n_inh;
        logic [2:0] f;
        o = own_now();
        f = mb[2:0];
        n_req = m_on && (dev_interrupt != 0) && !m_inh && !int_ack;
        n_inh = m_inh;
        if (INH_EN) begin
            if (jmp_jms_done) n_inh = 0;
            else if (cif_exec) n_inh = 1;
        end
        m_clr = o && (f == 3'd7);
        if (int_ack) begin
            m_on = 0; m_pend = 0;
        end else if (o && (f == 3'd0 || f == 3'd2 || f == 3'd7)) begin
            m_on = 0; m_pend = 0;
        end else if (o && f == 3'd1) begin
            if (!m_on) m_pend = 2;
        end else if (instr_done && m_pend > 0) begin
            m_pend--;
            if (m_pend == 0) m_on = 1;
        end
        m_req = n_req;
        m_inh = n_inh;
    endtask

    // one clock: check against the model mid-cycle, then advance the model
    task automatic tick();
        @(negedge clk);
        check_eq("io_selected", io_selected, (dev_selected != 0) || own_now());
        check_eq("io_skip", io_skip, skip_now());
        check_eq("ion", ion, m_on);
        check_eq("int_req", int_req, m_req);
        check_eq("io_clear_all", io_clear_all, m_clr);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        iot = 0; state = 4'd0; mb = 12'o7000; io_select = 6'o70;
        instr_done = 0; int_ack = 0; cif_exec = 0; jmp_jms_done = 0;
    endtask

    task automatic set_iot(input logic [2:0] f);
        idle();
        iot = 1; state = 4'd1; mb = {9'o600, f}; io_select = 6'o00;
    endtask

    task automatic make_on();
        set_iot(3'd1); tick();
        idle(); instr_done = 1; tick();
        tick();
        idle();
        check_eq("make_on_ion", ion, 1);
    endtask

    initial begin
        reset_n = 0;
        idle();
        dev_selected = 0; dev_skip = 0; dev_interrupt = 0;
        model_reset();
        #2;
        check_eq("rst_ion", ion, 0);
        check_eq("rst_int_req", int_req, 0);
        check_eq("rst_clear_all", io_clear_all, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        tick();

        // ION, then the delay through two instruction ends
        dev_interrupt = 8'h01;
        set_iot(3'd1); tick();
        check_eq("ion_armed", ion, 0);
        idle(); instr_done = 1; tick();
        check_eq("ion_delay_req", int_req, 0);
        idle(); tick(); tick();
        instr_done = 1; tick();
        check_eq("ion_on", ion, 1);
        check_eq("req_lag", int_req, 0);
        idle(); tick();
        check_eq("req_up", int_req, 1);
        int_ack = 1; tick();
        idle();
        check_eq("ack_req", int_req, 0);
        check_eq("ack_ion", ion, 0);
        dev_interrupt = 0; tick();

        // SKON skips once, then turns interrupts off
        make_on();
        set_iot(3'd0);
        #1 check_eq("skon_skip", io_skip, 1);
        tick();
        check_eq("skon_off", ion, 0);
        set_iot(3'd0);
        #1 check_eq("skon_again", io_skip, 0);
        tick(); idle();

        // merge of foreign device responses
        iot = 1; state = 4'd1; mb = 12'o6131; io_select = 6'o13;
        dev_skip = 8'h04; dev_selected = 8'h10;
        #1 check_eq("merge_skip", io_skip, 1);
        check_eq("merge_sel", io_selected, 1);
        dev_selected = 0; dev_skip = 0;
        #1 check_eq("merge_nosel", io_selected, 0);
        check_eq("merge_noskip", io_skip, 0);
        tick();
        set_iot(3'd3); dev_interrupt = 0;
        #1 check_eq("srq_none", io_skip, 0);
        dev_interrupt = 8'h80;
        #1 check_eq("srq_req", io_skip, 1);
        check_eq("srq_sel", io_selected, 1);
        tick(); idle(); dev_interrupt = 0;

        // CAF
        make_on();
        set_iot(3'd7); tick();
        check_eq("caf_pulse", io_clear_all, 1);
        check_eq("caf_ion", ion, 0);
        idle(); tick();
        check_eq("caf_end", io_clear_all, 0);

        // collisions with instr_done
        make_on();
        set_iot(3'd2); instr_done = 1; tick();
        check_eq("iof_done", ion, 0);
        idle(); instr_done = 1; tick();
        check_eq("iof_stays", ion, 0);
        set_iot(3'd1); instr_done = 1; tick();
        idle(); instr_done = 1; tick();
        check_eq("ion_done_arm", ion, 0);
        tick();
        check_eq("ion_done_on", ion, 1);
        idle(); tick();

        // async reset while in DELAY abandons progress
        set_iot(3'd2); tick();
        set_iot(3'd1); tick();
        idle(); instr_done = 1; tick();
        idle();
        #1 reset_n = 0;
        #1 check_eq("rst_delay_ion", ion, 0);
        check_eq("rst_delay_req", int_req, 0);
        model_reset();
        @(posedge clk); #1 reset_n = 1;
        instr_done = 1; tick();
        check_eq("rst_abandon", ion, 0);
        idle();

        // async reset drops a live int_req immediately
        dev_interrupt = 8'h02;
        make_on(); tick();
        check_eq("pre_rst_req", int_req, 1);
        #1 reset_n = 0;
        #1 check_eq("rst_live_req", int_req, 0);
        model_reset();
        @(posedge clk); #1 reset_n = 1;
        tick();

`ifdef PDP8_INTR_INHIBIT_EN
        make_on(); tick();
        check_eq("inh_pre", int_req, 1);
        cif_exec = 1; tick();
        cif_exec = 0; tick();
        check_eq("inh_req", int_req, 0);
        set_iot(3'd4);
        #1 check_eq("sinh_skip", io_skip, 1);
        tick(); idle();
        jmp_jms_done = 1; tick();
        jmp_jms_done = 0; tick();
        check_eq("inh_clear_req", int_req, 1);
        cif_exec = 1; jmp_jms_done = 1; tick();
        idle(); tick();
        check_eq("inh_both_clear", int_req, 1);
`endif
        dev_interrupt = 0;

        // randomized traffic
        for (int c = 0; c < 800; c++) begin
            int r;
            idle();
            iot = ($urandom_range(0, 3) != 0);
            state = 4'($urandom_range(0, 4));
            if (state == 4'd3) state = 4'd1;
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: mb[2:0] = 3'd1;
                4: mb[2:0] = 3'd0;
                5: mb[2:0] = 3'd2;
                6: mb[2:0] = 3'd3;
                7: mb[2:0] = 3'd4;
                8: mb[2:0] = 3'd7;
                default: mb[2:0] = 3'($urandom_range(0, 7));
            endcase
            mb[8:3] = ($urandom_range(0, 2) != 0) ? 6'o00 : 6'($urandom_range(0, 63));
            mb[11:9] = 3'($urandom_range(0, 7));
            io_select = mb[8:3];
            dev_selected = ($urandom_range(0, 3) == 0) ? NDEV'($urandom) : '0;
            dev_skip = ($urandom_range(0, 3) == 0) ? NDEV'($urandom) : '0;
            if ($urandom_range(0, 7) == 0) dev_interrupt = NDEV'($urandom) & NDEV'($urandom);
            instr_done = ($urandom_range(0, 2) == 0);
            int_ack = ($urandom_range(0, 31) == 0);
            cif_exec = ($urandom_range(0, 7) == 0);
            jmp_jms_done = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
